// File: rtl/vdcm_rc_pkg.sv
// Rate-control definitions shared by the encoder buffer model and the decoder offset logic.
package vdcm_rc_pkg;
  localparam int AVE_BLK_BITS        = 128;
  localparam int RC_OFFSET_INIT_DEF  = 8192;
  localparam int BLK_PIXELS          = 16;
  localparam int RC_OFFSET_PRECISION = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_STEADY,
    ST_DONE
  } rc_state_t;

  // Unsigned 16-bit value plus a signed delta, clamped to [0, 0xFFFF].
  function automatic logic [15:0] sat_add_u16(input logic [15:0] a,
                                              input logic signed [17:0] d);
    logic signed [17:0] t;
    t = $signed({2'b00, a}) + d;
    if (t < 0) return 16'h0000;
    if (t > 18'sh0_FFFF) return 16'hFFFF;
    return t[15:0];
  endfunction
endpackage

// File: rtl/rc_offset_slope_acc.sv
// End-of-slice rcOffset slope: fractional accumulator, threshold compare and offset update.
// The decoder-side offset logic instantiates this same block, so both ends stay bit-exact.
module rc_offset_slope_acc
  import vdcm_rc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic                           step,
  input  logic [11:0]                    blks_coded,
  input  logic [11:0]                    num_blks_in_slice,
  input  logic [7:0]                     num_blks_in_line,
  input  logic [15:0]                    offset_thd,
  input  logic [23:0]                    fullness_slope,
  output logic [RC_OFFSET_PRECISION-1:0] rc_offset
);
  logic [16:0]                    frac;
  logic [23:0]                    prod;
  logic signed [24:0]             th_raw;
  logic [23:0]                    th;
  logic [16:0]                    acc;
  logic                           in_region;
  logic                           last_blk;
  logic [RC_OFFSET_PRECISION-1:0] inc;

  always_comb begin
    prod      = {16'b0, num_blks_in_line} * {8'b0, offset_thd};
    th_raw    = $signed({13'b0, num_blks_in_slice}) - $signed({1'b0, prod});
    th        = th_raw[24] ? 24'd0 : th_raw[23:0];
    in_region = {12'b0, blks_coded} >= th;
    // frac[16] is always zero, so this is the 16-bit fraction sum with its carry in acc[16].
    acc       = frac + {1'b0, fullness_slope[15:0]};
    last_blk  = (blks_coded + 12'd1) == num_blks_in_slice;
    inc       = RC_OFFSET_PRECISION'(fullness_slope[23:16])
              + RC_OFFSET_PRECISION'(acc[16])
              + RC_OFFSET_PRECISION'(last_blk && acc[15]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frac      <= '0;
      rc_offset <= '0;
    end else if (clear) begin
      frac      <= '0;
      rc_offset <= '0;
    end else if (step && in_region) begin
      frac      <= {1'b0, acc[15:0]};
      rc_offset <= rc_offset + inc;
    end
  end
endmodule

// File: rtl/enc_rc_buffer_model.sv
// Encoder-side virtual rate-buffer model: fullness tracking with tx-delay and per-block
// drain, the rcOffsetInit ramp, and the end-of-slice rcOffset slope.
module enc_rc_buffer_model #(
  parameter int AVE_BLK_BITS       = vdcm_rc_pkg::AVE_BLK_BITS,
  parameter int RC_OFFSET_INIT_DEF = vdcm_rc_pkg::RC_OFFSET_INIT_DEF,
  parameter int BLK_PIXELS         = vdcm_rc_pkg::BLK_PIXELS,
  parameter int FULL_W             = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              slice_start,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [11:0]       blk_bits,
  input  logic [11:0]       num_blks_in_slice,
  input  logic [7:0]        num_blks_in_line,
  input  logic [7:0]        init_tx_delay,
  input  logic [15:0]       offset_thd,
  input  logic [23:0]       fullness_slope,
  output logic [FULL_W-1:0] buf_fullness,
  output logic [15:0]       rc_offset_init,
  output logic [15:0]       rc_offset,
  output logic [11:0]       blks_coded,
  output logic              overflow,
  output logic              underflow,
  output logic              slice_done
);
  import vdcm_rc_pkg::*;

  localparam int TW = FULL_W + 2;
  localparam logic signed [TW-1:0] FULL_MAX = $signed({2'b00, {FULL_W{1'b1}}});

  rc_state_t          state;
  logic               start_pend;
  logic [11:0]        cfg_n;
  logic [7:0]         cfg_line;
  logic [7:0]         cfg_delay;
  logic [15:0]        cfg_thd;
  logic [23:0]        cfg_slope;

  logic               active;
  logic               arm;
  logic               step;
  logic               last_blk;
  logic               in_ramp;
  logic [11:0]        blks_next;
  logic [19:0]        pix_coded;
  logic [19:0]        pix_delay;
  logic signed [TW-1:0] drain;
  logic signed [TW-1:0] t;

  function automatic logic [FULL_W-1:0] clamp_full(input logic signed [TW-1:0] v);
    if (v < 0) return '0;
    if (v > FULL_MAX) return '1;
    return v[FULL_W-1:0];
  endfunction

  always_comb begin
    active    = (state == ST_DELAY) || (state == ST_STEADY);
    arm       = ((state == ST_IDLE) && (slice_start || start_pend)) || (active && slice_start);
    step      = blk_valid && blk_ready && active && !slice_start;
    blks_next = blks_coded + 12'd1;
    last_blk  = blks_next == cfg_n;
    pix_coded = 20'(blks_next) * 20'(BLK_PIXELS);
    pix_delay = 20'(cfg_delay) * 20'(BLK_PIXELS);
    in_ramp   = pix_coded <= pix_delay;
    drain     = (state == ST_STEADY) ? TW'(AVE_BLK_BITS) : '0;
    t         = $signed({2'b00, buf_fullness}) + $signed({{(TW-12){1'b0}}, blk_bits}) - drain;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      start_pend     <= 1'b0;
      blk_ready      <= 1'b0;
      buf_fullness   <= '0;
      rc_offset_init <= 16'(RC_OFFSET_INIT_DEF);
      blks_coded     <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      slice_done     <= 1'b0;
      cfg_n          <= '0;
      cfg_line       <= '0;
      cfg_delay      <= '0;
      cfg_thd        <= '0;
      cfg_slope      <= '0;
    end else begin
      slice_done <= 1'b0;
      if (arm) begin
        state          <= (init_tx_delay == 8'd0) ? ST_STEADY : ST_DELAY;
        start_pend     <= 1'b0;
        blk_ready      <= 1'b1;
        buf_fullness   <= '0;
        rc_offset_init <= 16'(RC_OFFSET_INIT_DEF);
        blks_coded     <= '0;
        overflow       <= 1'b0;
        underflow      <= 1'b0;
        cfg_n          <= num_blks_in_slice;
        cfg_line       <= num_blks_in_line;
        cfg_delay      <= init_tx_delay;
        cfg_thd        <= offset_thd;
        cfg_slope      <= fullness_slope;
      end else if (state == ST_DONE) begin
        // A start request landing in the DONE cycle is replayed from IDLE.
        state      <= ST_IDLE;
        start_pend <= slice_start;
      end else if (step) begin
        blks_coded   <= blks_next;
        buf_fullness <= clamp_full(t);
        if (t < 0) underflow <= 1'b1;
        if (t > FULL_MAX) overflow <= 1'b1;
        if (in_ramp)
          rc_offset_init <= sat_add_u16(rc_offset_init, -$signed(18'(AVE_BLK_BITS)));
        if (last_blk) begin
          state      <= ST_DONE;
          blk_ready  <= 1'b0;
          slice_done <= 1'b1;
        end else if ((state == ST_DELAY) && (blks_next == {4'b0, cfg_delay})) begin
          state <= ST_STEADY;
        end
      end
    end
  end

  rc_offset_slope_acc u_slope (
    .clk               (clk),
    .rstn              (rstn),
    .clear             (arm),
    .step              (step),
    .blks_coded        (blks_coded),
    .num_blks_in_slice (cfg_n),
    .num_blks_in_line  (cfg_line),
    .offset_thd        (cfg_thd),
    .fullness_slope    (cfg_slope),
    .rc_offset         (rc_offset)
  );
endmodule

// File: tb/tb_enc_rc_buffer_model.sv
// Directed bench for enc_rc_buffer_model with a behavioural model feeding a scoreboard queue.
module tb_enc_rc_buffer_model;
  logic        clk = 1'b0;
  logic        rstn;
  logic        slice_start;
  logic        blk_valid;
  logic        blk_ready;
  logic [11:0] blk_bits;
  logic [11:0] num_blks_in_slice;
  logic [7:0]  num_blks_in_line;
  logic [7:0]  init_tx_delay;
  logic [15:0] offset_thd;
  logic [23:0] fullness_slope;
  logic [15:0] buf_fullness;
  logic [15:0] rc_offset_init;
  logic [15:0] rc_offset;
  logic [11:0] blks_coded;
  logic        overflow;
  logic        underflow;
  logic        slice_done;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    int full;
    int init;
    int off;
    int blks;
    bit ovf;
    bit unf;
    bit done;
  } exp_t;
  exp_t sb[$];

  int c_n, c_line, c_delay, c_thd, c_slope;
  int m_full, m_init, m_off, m_frac, m_blks;
  bit m_ovf, m_unf, m_steady;

  always #5 clk = ~clk;

  enc_rc_buffer_model dut (
    .clk               (clk),
    .rstn              (rstn),
    .slice_start       (slice_start),
    .blk_valid         (blk_valid),
    .blk_ready         (blk_ready),
    .blk_bits          (blk_bits),
    .num_blks_in_slice (num_blks_in_slice),
    .num_blks_in_line  (num_blks_in_line),
    .init_tx_delay     (init_tx_delay),
    .offset_thd        (offset_thd),
    .fullness_slope    (fullness_slope),
    .buf_fullness      (buf_fullness),
    .rc_offset_init    (rc_offset_init),
    .rc_offset         (rc_offset),
    .blks_coded        (blks_coded),
    .overflow          (overflow),
    .underflow         (underflow),
    .slice_done        (slice_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_full"}, buf_fullness, 0);
    chk({pfx, "_off"}, rc_offset, 0);
    chk({pfx, "_init"}, rc_offset_init, 8192);
    chk({pfx, "_blks"}, blks_coded, 0);
    chk({pfx, "_ovf"}, overflow, 0);
    chk({pfx, "_unf"}, underflow, 0);
    chk({pfx, "_done"}, slice_done, 0);
    chk({pfx, "_ready"}, blk_ready, 0);
  endtask

  task automatic set_cfg(input int n, input int line, input int delay, input int thd,
                         input int slope);
    c_n = n; c_line = line; c_delay = delay; c_thd = thd; c_slope = slope;
    num_blks_in_slice = 12'(n);
    num_blks_in_line  = 8'(line);
    init_tx_delay     = 8'(delay);
    offset_thd        = 16'(thd);
    fullness_slope    = 24'(slope);
  endtask

  task automatic model_start();
    m_full = 0; m_init = 8192; m_off = 0; m_frac = 0; m_blks = 0;
    m_ovf = 0; m_unf = 0; m_steady = (c_delay == 0);
  endtask

  task automatic model_block(input int bits);
    int t, th, acc;
    exp_t e;
    t = m_full + bits - (m_steady ? 128 : 0);
    if (t < 0) begin m_full = 0; m_unf = 1; end
    else if (t > 65535) begin m_full = 65535; m_ovf = 1; end
    else m_full = t;
    if (m_blks + 1 <= c_delay) m_init = (m_init >= 128) ? m_init - 128 : 0;
    th = c_n - c_line * c_thd;
    if (th < 0) th = 0;
    if (m_blks >= th) begin
      acc    = m_frac + (c_slope & 'hFFFF);
      m_frac = acc & 'hFFFF;
      m_off  = m_off + (c_slope >> 16) + (acc >> 16);
      if ((m_blks + 1 == c_n) && (m_frac >= 'h8000)) m_off++;
      m_off = m_off & 'hFFFF;
    end
    m_blks++;
    if (m_blks == c_delay) m_steady = 1;
    e.full = m_full; e.init = m_init; e.off = m_off; e.blks = m_blks;
    e.ovf = m_ovf; e.unf = m_unf; e.done = (m_blks == c_n);
    sb.push_back(e);
  endtask

  task automatic start_slice(input int n, input int line, input int delay, input int thd,
                             input int slope);
    set_cfg(n, line, delay, thd, slope);
    slice_start = 1'b1;
    @(posedge clk); #1;
    slice_start = 1'b0;
    model_start();
    chk("arm_blks", blks_coded, 0);
    chk("arm_init", rc_offset_init, 8192);
    chk("arm_full", buf_fullness, 0);
    chk("arm_off", rc_offset, 0);
    chk("arm_done", slice_done, 0);
    chk("arm_ready", blk_ready, 1);
  endtask

  task automatic send_block(input int bits);
    exp_t e;
    int w;
    w = 0;
    while (blk_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait", blk_ready, 1);
    model_block(bits);
    blk_valid = 1'b1;
    blk_bits  = 12'(bits);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    n_asrt++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_pop: observed %0d entries required >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fullness", buf_fullness, e.full);
      chk("offset_init", rc_offset_init, e.init);
      chk("offset", rc_offset, e.off);
      chk("blks_coded", blks_coded, e.blks);
      chk("overflow", overflow, e.ovf);
      chk("underflow", underflow, e.unf);
      chk("slice_done", slice_done, e.done);
    end
  endtask

  task automatic leave_done();
    @(posedge clk); #1;
    chk("done_pulse_end", slice_done, 0);
    chk("idle_ready", blk_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; slice_start = 1'b0; blk_valid = 1'b0; blk_bits = '0;
    set_cfg(1, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start_ready", blk_ready, 0);

    // Basic drain with a two-block tx delay
    start_slice(4, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) send_block(128);
    chk("basic_full_end", buf_fullness, 256);
    chk("basic_init_end", rc_offset_init, 7936);
    leave_done();

    // Slope region over the last four blocks
    start_slice(10, 2, 2, 2, 'h018000);
    for (int i = 0; i < 10; i++) send_block(int'($urandom_range(0, 300)));
    chk("slope_end", rc_offset, 6);
    leave_done();

    // Negative threshold clamps to 0; last block rounds up
    start_slice(3, 1, 1, 5, 'h00A000);
    for (int i = 0; i < 3; i++) send_block(200);
    chk("round_end", rc_offset, 2);
    leave_done();

    // Underflow with zero delay and empty blocks
    start_slice(3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send_block(0);
    // Start request during DONE is deferred by one cycle
    set_cfg(20, 1, 200, 0, 0);
    slice_start = 1'b1;
    @(posedge clk); #1;
    slice_start = 1'b0;
    chk("pend_idle_ready", blk_ready, 0);
    chk("pend_idle_done", slice_done, 0);
    @(posedge clk); #1;
    chk("pend_armed_ready", blk_ready, 1);
    chk("pend_armed_blks", blks_coded, 0);
    chk("pend_armed_unf", underflow, 0);
    model_start();

    // Overflow: no drain during a long delay
    for (int i = 0; i < 20; i++) send_block(4095);
    chk("ovf_full_end", buf_fullness, 65535);
    chk("ovf_flag_end", overflow, 1);
    leave_done();

    // Abort mid-slice after three blocks
    start_slice(8, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) send_block(300);
    start_slice(8, 1, 2, 0, 'h010000);

    // Asynchronous reset mid-slice in STEADY
    for (int i = 0; i < 3; i++) send_block(250);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", blk_ready, 0);
    chk("post_rst_blks", blks_coded, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
